// File: rtl/avmm_pkg.sv
// avmm_pkg: shared definitions for the Avalon-MM register slave.
//   - avmm_state_e : access FSM states (IDLE, BUSY, ACK)
//   - ADDR_STATUS  : sticky error/status register address
//   - ADDR_XCNT    : transaction counter address (AVMM_XACT_CNT_EN builds only)
//   - STAT_ERR_*   : STATUS bit positions
//   - RD_DEFAULT   : value returned by reads of unmapped addresses
package avmm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } avmm_state_e;

  localparam logic [7:0] ADDR_STATUS = 8'hFF;
  localparam logic [7:0] ADDR_XCNT   = 8'hFE;

  localparam int unsigned STAT_ERR_RW   = 0;
  localparam int unsigned STAT_ERR_ADDR = 1;

  localparam logic [7:0] RD_DEFAULT = 8'h00;

endpackage

// File: rtl/avmm_wait_ctr.sv
// avmm_wait_ctr: wait-state down-counter.
//   clk, reset : clock, synchronous active-high reset
//   load       : load load_val (has priority over en)
//   en         : decrement by one, saturating at zero
//   load_val   : value loaded on load
//   zero       : high while the count is zero
module avmm_wait_ctr #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/avmm_reg_slave.sv
// avmm_reg_slave: Avalon-MM register slave with programmable wait states.
//   clk, reset  : clock, synchronous active-high reset
//   address     : register address (8 bits)
//   write, read : transfer strobes
//   writedata   : write data (8 bits)
//   waitrequest : high while busy; its falling edge acknowledges a transfer
//   readdata    : read data, updated when a read completes, otherwise held
// Map: 0..NUM_REGS-1 R/W data, 0xFE transaction counter (only when
// AVMM_XACT_CNT_EN is defined, else unmapped), 0xFF STATUS (W1C:
// bit0 read+write together, bit1 unmapped address).
module avmm_reg_slave
  import avmm_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] address,
  input  logic       write,
  input  logic       read,
  input  logic [7:0] writedata,
  output logic       waitrequest,
  output logic [7:0] readdata
);

  localparam int unsigned IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0]  NUM_REGS_B = 8'(NUM_REGS);
  localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_STATES - 1);

  avmm_state_e state_q, state_d;
  logic        ctr_load, ctr_en, ctr_zero, commit;
  logic        wait_q;

  logic [7:0]  cmd_addr, cmd_wdata;
  logic        cmd_wr, cmd_rd;

  logic [7:0]  regs [NUM_REGS];
  logic [1:0]  status_q, status_d;
  logic [7:0]  readdata_q;

  logic             hit_data, hit_stat, xcnt_ok, addr_err, rw_err;
  logic [IDX_W-1:0] idx;
  logic [7:0]       rd_val;

`ifdef AVMM_XACT_CNT_EN
  logic [7:0] xcnt_q;
`endif

  avmm_wait_ctr #(.W(4)) u_wait_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (ctr_load),
    .en       (ctr_en),
    .load_val (WAIT_LOAD),
    .zero     (ctr_zero)
  );

  // FSM state register; waitrequest is registered so it reads high
  // throughout reset and drops on the first edge out of it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wait_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      wait_q  <= (state_d == ST_BUSY);
    end
  end

  always_comb begin
    state_d  = state_q;
    ctr_load = 1'b0;
    ctr_en   = 1'b0;
    commit   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (read || write) begin
          ctr_load = 1'b1;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (ctr_zero) begin
          commit  = 1'b1;
          state_d = ST_ACK;
        end else begin
          ctr_en = 1'b1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Command capture at accept; bus changes during BUSY are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_wr    <= 1'b0;
      cmd_rd    <= 1'b0;
    end else if (ctr_load) begin
      cmd_addr  <= address;
      cmd_wdata <= writedata;
      cmd_wr    <= write;
      cmd_rd    <= read;
    end
  end

  // Address decode of the latched command.
  always_comb begin
    hit_data = (cmd_addr < NUM_REGS_B);
    hit_stat = (cmd_addr == ADDR_STATUS);
`ifdef AVMM_XACT_CNT_EN
    xcnt_ok  = (cmd_addr == ADDR_XCNT) && !cmd_wr;
`else
    xcnt_ok  = 1'b0;
`endif
    addr_err = !(hit_data || hit_stat || xcnt_ok);
    rw_err   = cmd_rd && cmd_wr;
    idx      = cmd_addr[IDX_W-1:0];

    rd_val = RD_DEFAULT;
    if (hit_data) begin
      rd_val = regs[idx];
    end else if (hit_stat) begin
      rd_val = {6'b0, status_q};
`ifdef AVMM_XACT_CNT_EN
    end else if (xcnt_ok) begin
      rd_val = xcnt_q;
`endif
    end

    // W1C clear first, then OR in this access's errors so a set wins.
    status_d = status_q;
    if (cmd_wr && hit_stat) begin
      status_d = status_q & ~cmd_wdata[1:0];
    end
    if (rw_err)   status_d[STAT_ERR_RW]   = 1'b1;
    if (addr_err) status_d[STAT_ERR_ADDR] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      status_q   <= '0;
      readdata_q <= RD_DEFAULT;
    end else if (commit) begin
      if (cmd_wr && hit_data) begin
        regs[idx] <= cmd_wdata;
      end
      status_q <= status_d;
      if (cmd_rd && !cmd_wr) begin
        readdata_q <= rd_val;
      end
    end
  end

`ifdef AVMM_XACT_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      xcnt_q <= '0;
    end else if (commit) begin
      xcnt_q <= xcnt_q + 8'd1;
    end
  end
`endif

  assign waitrequest = wait_q;
  assign readdata    = readdata_q;

endmodule

// File: tb/tb_avmm_reg_slave.sv
module tb_avmm_reg_slave;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] address;
  logic       write;
  logic       read;
  logic [7:0] writedata;
  logic       waitrequest;
  logic [7:0] readdata;

  int n_vec = 0;
  int n_err = 0;

  avmm_reg_slave #(.NUM_REGS(16), .WAIT_STATES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .write       (write),
    .read        (read),
    .writedata   (writedata),
    .waitrequest (waitrequest),
    .readdata    (readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         w;
    bit         r;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl[23];

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called #1 after an edge with the DUT in IDLE. Returns readdata at the
  // waitrequest fall and the number of sampled cycles waitrequest was high.
  task automatic xfer(input bit w, input bit r, input logic [7:0] a,
                      input logic [7:0] d, output logic [7:0] rd,
                      output int busy);
    address = a; write = w; read = r; writedata = d;
    @(posedge clk); #1;
    busy = 0;
    while (waitrequest && busy < 40) begin
      busy++;
      @(posedge clk); #1;
    end
    rd = readdata;
    write = 1'b0; read = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] rd;
    int         busy;

    tbl[0]  = '{1'b1, 1'b0, 8'h01, 8'hB5, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 8'h01, 8'h00, 8'hB5};
    tbl[2]  = '{1'b1, 1'b0, 8'h00, 8'h11, 8'hB5};
    tbl[3]  = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h11};
    tbl[4]  = '{1'b1, 1'b1, 8'h03, 8'hC8, 8'h11};
    tbl[5]  = '{1'b0, 1'b1, 8'h03, 8'h00, 8'hC8};
    tbl[6]  = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h01};
    tbl[7]  = '{1'b1, 1'b0, 8'hFF, 8'h01, 8'h01};
    tbl[8]  = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h00};
    tbl[9]  = '{1'b0, 1'b1, 8'h20, 8'h00, 8'h00};
    tbl[10] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h02};
    tbl[11] = '{1'b1, 1'b0, 8'hFF, 8'h03, 8'h02};
    tbl[12] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h00};
    tbl[13] = '{1'b1, 1'b0, 8'h0F, 8'h7E, 8'h00};
    tbl[14] = '{1'b0, 1'b1, 8'h0F, 8'h00, 8'h7E};
    tbl[15] = '{1'b1, 1'b0, 8'h10, 8'h99, 8'h7E};
    tbl[16] = '{1'b0, 1'b1, 8'h10, 8'h00, 8'h00};
    tbl[17] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h02};
    tbl[18] = '{1'b1, 1'b1, 8'hFF, 8'h03, 8'h02};
    tbl[19] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h01};
    tbl[20] = '{1'b1, 1'b0, 8'hFF, 8'h01, 8'h01};
    tbl[21] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h00};
    tbl[22] = '{1'b0, 1'b1, 8'h01, 8'h00, 8'hB5};

    reset = 1'b1; address = '0; write = 1'b0; read = 1'b0; writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_waitreq", int'(waitrequest), 1);
    check("reset_readdata", int'(readdata), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("first_edge_waitreq", int'(waitrequest), 0);

    for (int i = 0; i < 23; i++) begin
      xfer(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, rd, busy);
      check($sformatf("vec%0d_busy", i), busy, 2);
      check($sformatf("vec%0d_rd", i), int'(rd), int'(tbl[i].exp_rd));
    end

`ifndef AVMM_XACT_CNT_EN
    xfer(1'b0, 1'b1, 8'hFE, 8'h00, rd, busy);
    check("fe_unmapped_rd", int'(rd), 0);
    xfer(1'b0, 1'b1, 8'hFF, 8'h00, rd, busy);
    check("fe_unmapped_status", int'(rd), 2);
    xfer(1'b1, 1'b0, 8'hFF, 8'h02, rd, busy);
`endif

    // Reset during the second BUSY cycle of a write aborts it.
    address = 8'h05; write = 1'b1; read = 1'b0; writedata = 8'hAA;
    @(posedge clk); #1;
    check("midbusy_accept", int'(waitrequest), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midbusy_reset_waitreq", int'(waitrequest), 1);
    check("midbusy_reset_readdata", int'(readdata), 0);
    reset = 1'b0; write = 1'b0;
    @(posedge clk); #1;
    check("midbusy_release", int'(waitrequest), 0);
    xfer(1'b0, 1'b1, 8'h05, 8'h00, rd, busy);
    check("midbusy_reg5", int'(rd), 0);
    xfer(1'b0, 1'b1, 8'h01, 8'h00, rd, busy);
    check("midbusy_reg1_cleared", int'(rd), 0);
    xfer(1'b0, 1'b1, 8'hFF, 8'h00, rd, busy);
    check("midbusy_status", int'(rd), 0);

    // Next command presented during ACK is accepted once, after ACK.
    address = 8'h02; write = 1'b1; read = 1'b0; writedata = 8'h5A;
    @(posedge clk); #1;
    busy = 0;
    while (waitrequest && busy < 40) begin
      busy++;
      @(posedge clk); #1;
    end
    check("b2b_wr_busy", busy, 2);
    address = 8'h02; write = 1'b0; read = 1'b1;
    @(posedge clk); #1;
    check("b2b_ack_ignored", int'(waitrequest), 0);
    @(posedge clk); #1;
    check("b2b_accept", int'(waitrequest), 1);
    busy = 1;
    while (waitrequest && busy < 40) begin
      @(posedge clk); #1;
      if (waitrequest) busy++;
    end
    check("b2b_rd_busy", busy, 2);
    check("b2b_rd_data", int'(readdata), 8'h5A);
    read = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b_no_reaccept", int'(waitrequest), 0);

`ifdef AVMM_XACT_CNT_EN
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 255; i++) begin
      xfer(1'b1, 1'b0, 8'h00, 8'(i), rd, busy);
    end
    xfer(1'b0, 1'b1, 8'hFE, 8'h00, rd, busy);
    check("xcnt_255", int'(rd), 8'hFF);
    xfer(1'b0, 1'b1, 8'hFE, 8'h00, rd, busy);
    check("xcnt_wrap", int'(rd), 8'h00);
    xfer(1'b1, 1'b0, 8'hFE, 8'h55, rd, busy);
    xfer(1'b0, 1'b1, 8'hFF, 8'h00, rd, busy);
    check("xcnt_write_err", int'(rd), 8'h02);
    xfer(1'b0, 1'b1, 8'hFE, 8'h00, rd, busy);
    check("xcnt_after_err", int'(rd), 8'h03);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
